// File: rtl/cry_det_pkg.sv
// Shared types and helpers for the cry pattern detector: alarm state encoding,
// default character width, and a select-width helper that is safe for size-1 sets.
package cry_det_pkg;

  localparam int CRY_CHAR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ALARM = 2'd2
  } alarm_state_e;

  // Width of a select bus over n items; never returns 0 so ports stay legal.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cry_pattern_matcher.sv
// One programmable pattern: storage with a single-character write port and a
// full-window comparator. Character 0 of the pattern sits in the most significant slot.
module cry_pattern_matcher
  import cry_det_pkg::*;
#(
  parameter int                          CHAR_W  = CRY_CHAR_W,
  parameter int                          PAT_LEN = 4,
  parameter int                          IDX_W   = 2,
  parameter logic [PAT_LEN*CHAR_W-1:0]   DEFAULT = '0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        we,
  input  logic [IDX_W-1:0]            idx,
  input  logic [CHAR_W-1:0]           wchar,
  input  logic [PAT_LEN*CHAR_W-1:0]   window,
  input  logic                        en,
  output logic                        hit
);

  logic [PAT_LEN-1:0][CHAR_W-1:0] pat;

  // NOTE: this small storage is deliberately reset, because the pattern must
  // come back to its default contents after rstn rather than hold stale data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat <= DEFAULT;
    end else if (we) begin
      for (int i = 0; i < PAT_LEN; i++) begin
        if (int'(idx) == i) pat[PAT_LEN-1-i] <= wchar;
      end
    end
  end

  assign hit = en && (pat == window);

endmodule

// File: rtl/cry_pattern_detector.sv
// Multi-pattern cry detector: shared character history, N_PAT matchers, a
// saturating hit counter with quiet-window timeout, and a sticky alarm FSM.
module cry_pattern_detector
  import cry_det_pkg::*;
#(
  parameter int CHAR_W  = CRY_CHAR_W,
  parameter int PAT_LEN = 4,
  parameter int N_PAT   = 2,
  parameter int CNT_W   = 4,
  parameter int QUIET   = 16,
  parameter logic [N_PAT*PAT_LEN*CHAR_W-1:0] DEFAULT_PAT = {"WAWA", "MOWA"},
  localparam int SEL_W = sel_w(N_PAT),
  localparam int IDX_W = sel_w(PAT_LEN)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_char,
  input  logic [CNT_W-1:0]  thresh,
  input  logic              pat_we,
  input  logic [SEL_W-1:0]  pat_sel,
  input  logic [IDX_W-1:0]  pat_idx,
  input  logic [CHAR_W-1:0] pat_char,
  input  logic [N_PAT-1:0]  pat_en,
  input  logic              alarm_clr,
  output logic [N_PAT-1:0]  match,
  output logic [CNT_W-1:0]  hits,
  output logic              out
);

  localparam int FILL_W  = $clog2(PAT_LEN + 1);
  localparam int QUIET_W = $clog2(QUIET + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0]  FILL_REQ  = FILL_W'(PAT_LEN - 1);
  localparam logic [QUIET_W-1:0] QUIET_END = QUIET_W'(QUIET);
  localparam logic [CNT_W-1:0]   HITS_MAX  = '1;

  // Only the newest PAT_LEN-1 characters can ever take part in a match.
  logic [PAT_LEN-2:0][CHAR_W-1:0] hist;
  logic [PAT_LEN-1:0][CHAR_W-1:0] window;
  logic [FILL_W-1:0]              fill;
  logic                           fill_ok;

  logic [N_PAT-1:0]   hit_raw;
  logic [N_PAT-1:0]   match_d;
  logic               any_match;
  logic [CNT_W-1:0]   th_eff;
  logic [CNT_W-1:0]   hits_d;
  logic [CNT_W-1:0]   hits_sat;
  logic [QUIET_W-1:0] quiet;
  logic [QUIET_W-1:0] quiet_d;
  alarm_state_e       state;
  alarm_state_e       state_d;

  assign window  = {hist, in_char};
  assign fill_ok = (fill >= FILL_REQ);

  for (genvar p = 0; p < N_PAT; p++) begin : g_pat
    cry_pattern_matcher #(
      .CHAR_W  (CHAR_W),
      .PAT_LEN (PAT_LEN),
      .IDX_W   (IDX_W),
      .DEFAULT (DEFAULT_PAT[p*PAT_LEN*CHAR_W +: PAT_LEN*CHAR_W])
    ) u_matcher (
      .clk    (clk),
      .rstn   (rstn),
      .we     (pat_we && (int'(pat_sel) == p)),
      .idx    (pat_idx),
      .wchar  (pat_char),
      .window (window),
      .en     (pat_en[p]),
      .hit    (hit_raw[p])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist <= '0;
      fill <= '0;
    end else if (in_valid) begin
      hist <= window[PAT_LEN-2:0];
      if (fill != FILL_FULL) fill <= fill + 1'b1;
    end
  end

  assign match_d   = (in_valid && fill_ok) ? hit_raw : '0;
  assign any_match = |match_d;
  assign th_eff    = (thresh == '0) ? CNT_W'(1) : thresh;
  assign hits_sat  = (hits == HITS_MAX) ? hits : hits + 1'b1;

  // NOTE: every output of this block is defaulted first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    hits_d  = hits;
    quiet_d = quiet;
    state_d = state;
    if (alarm_clr) begin
      hits_d  = '0;
      quiet_d = '0;
      state_d = IDLE;
    end else if (any_match) begin
      hits_d  = hits_sat;
      quiet_d = '0;
      if (state != ALARM) state_d = (hits_sat >= th_eff) ? ALARM : COUNT;
    end else if (in_valid) begin
      if (quiet + 1'b1 == QUIET_END) begin
        quiet_d = '0;
        hits_d  = '0;
        if (state == COUNT) state_d = IDLE;
      end else begin
        quiet_d = quiet + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      hits  <= '0;
      quiet <= '0;
      match <= '0;
    end else begin
      state <= state_d;
      hits  <= hits_d;
      quiet <= quiet_d;
      match <= match_d;
    end
  end

  assign out = (state == ALARM);

endmodule

// File: tb/tb_cry_pattern_detector.sv
// Self-checking bench for cry_pattern_detector: directed scenarios plus random
// traffic, compared every cycle against a character-queue reference model.
module tb_cry_pattern_detector;

  localparam int PAT_LEN = 4;
  localparam int N_PAT   = 2;
  localparam int QUIET   = 16;
  localparam int HMAX    = 15;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic [3:0] thresh = 4'd1;
  logic       pat_we = 1'b0;
  logic [0:0] pat_sel = 1'b0;
  logic [1:0] pat_idx = 2'd0;
  logic [7:0] pat_char = 8'h00;
  logic [1:0] pat_en = 2'b11;
  logic       alarm_clr = 1'b0;
  logic [1:0] match;
  logic [3:0] hits;
  logic       out;

  cry_pattern_detector dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_char(in_char),
    .thresh(thresh), .pat_we(pat_we), .pat_sel(pat_sel), .pat_idx(pat_idx),
    .pat_char(pat_char), .pat_en(pat_en), .alarm_clr(alarm_clr),
    .match(match), .hits(hits), .out(out)
  );

  always #5 clk = ~clk;

  // Reference model: patterns as character arrays, history as a queue of
  // recently received characters (oldest first).
  byte unsigned pats[N_PAT][PAT_LEN];
  byte unsigned hist[$];
  int           m_hits;
  int           m_quiet;
  bit           m_alarm;
  bit [1:0]     m_match;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    string d0 = "MOWA";
    string d1 = "WAWA";
    hist.delete();
    m_hits = 0; m_quiet = 0; m_alarm = 0; m_match = '0;
    for (int i = 0; i < PAT_LEN; i++) begin
      pats[0][i] = d0[i];
      pats[1][i] = d1[i];
    end
  endtask

  task automatic model_edge();
    bit [1:0] mv = '0;
    int th = (thresh == 0) ? 1 : int'(thresh);
    if (in_valid && hist.size() == PAT_LEN - 1) begin
      for (int p = 0; p < N_PAT; p++) begin
        bit eq = pat_en[p];
        for (int i = 0; i < PAT_LEN - 1; i++) if (hist[i] != pats[p][i]) eq = 0;
        if (in_char != pats[p][PAT_LEN-1]) eq = 0;
        mv[p] = eq;
      end
    end
    if (in_valid) begin
      hist.push_back(in_char);
      if (hist.size() > PAT_LEN - 1) void'(hist.pop_front());
    end
    if (alarm_clr) begin
      m_hits = 0; m_quiet = 0; m_alarm = 0;
    end else if (mv != 0) begin
      m_hits  = (m_hits < HMAX) ? m_hits + 1 : HMAX;
      m_quiet = 0;
      if (m_hits >= th) m_alarm = 1;
    end else if (in_valid) begin
      m_quiet++;
      if (m_quiet == QUIET) begin
        m_quiet = 0;
        m_hits  = 0;
      end
    end
    if (pat_we && int'(pat_sel) < N_PAT && int'(pat_idx) < PAT_LEN)
      pats[pat_sel][pat_idx] = pat_char;
    m_match = mv;
  endtask

  task automatic check_outs(input string tag);
    check({tag, "/match"}, 32'(match), 32'(m_match));
    check({tag, "/hits"},  32'(hits),  32'(m_hits));
    check({tag, "/out"},   32'(out),   32'(m_alarm));
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic clr, input string tag);
    in_valid  = v;
    in_char   = c;
    alarm_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
    alarm_clr = 1'b0;
    pat_we    = 1'b0;
  endtask

  task automatic send(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0, tag);
  endtask

  task automatic wr(input int sel, input int idx, input logic [7:0] ch);
    pat_we   = 1'b1;
    pat_sel  = 1'(sel);
    pat_idx  = 2'(idx);
    pat_char = ch;
    step(1'b1, "Z", 1'b0, "wr");
  endtask

  initial begin
    string alpha = "WAMOBNKX";
    string bank  = "BANK";

    model_reset();
    #12;
    check("rst/match", 32'(match), 0);
    check("rst/hits",  32'(hits),  0);
    check("rst/out",   32'(out),   0);
    @(negedge clk) rstn = 1'b1;

    // Default patterns, thresh 1: MOWA hits pattern 0 and alarms at once.
    thresh = 4'd1;
    send("BANKMOWA", "dflt");
    check("dflt/match_last", 32'(match), 32'h1);
    check("dflt/out_last",   32'(out),   1);
    send("WW", "sticky");
    check("sticky/out", 32'(out), 1);

    // Overlapping WAWA hits with thresh 2.
    step(1'b0, "X", 1'b1, "clr");
    thresh = 4'd2;
    send("WAWAWA", "ovl");
    check("ovl/hits", 32'(hits), 2);
    check("ovl/out",  32'(out),  1);

    // Quiet timeout with idle gaps in the stream.
    step(1'b0, "X", 1'b1, "clr");
    thresh = 4'd3;
    send("MOWA", "qt");
    check("qt/hits1", 32'(hits), 1);
    for (int i = 0; i < QUIET; i++) begin
      step(1'b1, "X", 1'b0, "qt");
      if (i % 4 == 0) step(1'b0, "X", 1'b0, "qt_gap");
    end
    check("qt/hits0", 32'(hits), 0);
    check("qt/out",   32'(out),  0);

    // Clear on the same edge as a completing match.
    thresh = 4'd1;
    send("WAW", "cp");
    step(1'b1, "A", 1'b1, "cp");
    check("cp/match", 32'(match), 32'h2);
    check("cp/hits",  32'(hits),  0);
    check("cp/out",   32'(out),   0);

    // Reprogram pattern 0 to BANK mid-stream.
    for (int i = 0; i < PAT_LEN; i++) wr(0, i, bank[i]);
    send("BANK", "prog");
    check("prog/match_bank", 32'(match), 32'h1);
    send("MOWA", "prog");
    check("prog/match_mowa", 32'(match), 32'h0);
    pat_en = 2'b10;
    send("BANK", "dis");
    check("dis/match", 32'(match), 32'h0);
    pat_en = 2'b11;

    // Hit counter saturation.
    step(1'b0, "X", 1'b1, "clr");
    thresh = 4'd15;
    for (int i = 0; i < 20; i++) send("WA", "sat");
    check("sat/hits", 32'(hits), 15);
    check("sat/out",  32'(out),  1);

    // Asynchronous reset in the middle of a pattern.
    step(1'b0, "X", 1'b1, "clr");
    thresh = 4'd1;
    send("MOW", "ar");
    #2 rstn = 1'b0;
    model_reset();
    #1;
    check("ar/match", 32'(match), 0);
    check("ar/hits",  32'(hits),  0);
    check("ar/out",   32'(out),   0);
    @(negedge clk) rstn = 1'b1;
    step(1'b1, "A", 1'b0, "ar_post");
    check("ar/no_match", 32'(match), 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) thresh = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) pat_en = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        pat_we   = 1'b1;
        pat_sel  = 1'($urandom_range(0, 1));
        pat_idx  = 2'($urandom_range(0, 3));
        pat_char = alpha[$urandom_range(0, 7)];
      end
      step($urandom_range(0, 9) < 8, alpha[$urandom_range(0, 7)],
           $urandom_range(0, 49) == 0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
